// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          FETCH_XLEN = 32;

  // Default-width view of a prefetched entry; the top re-declares it at its own XLEN.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with first-word-fall-through output and single-cycle clear.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so push at full is fine alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with valid/ready memory port, pc-tag tracking, prefetch queue
// and redirect-driven discard of stale responses; drives the IF/ID register.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  input  logic            flush_IF,
  output logic            valid_IF,
  output logic [31:0]     instrCode_IF,
  output logic [XLEN-1:0] PCOutData_IF,
  output logic [XLEN-1:0] PC_4_AdderResult_IF
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt, tag_count, q_count, outstanding;
  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] tag_pc;
  entry_t          q_din, q_dout;
  logic            accept, rsp_keep, rsp_drop, q_pop;
  logic            q_empty, q_full, tag_empty, tag_full;
  logic            unused_flags;

  // Every in-flight request is either tagged (will be kept) or counted for discard.
  assign outstanding    = tag_count + drop_cnt;
  assign credit_sum     = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !reset && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && !tag_empty;
  assign q_pop    = !reset && !flush_IF && !redirect_valid && !stall && !q_empty;
  assign q_din    = '{pc: tag_pc, instr: imem_rsp_data};

  // Credit accounting keeps both FIFOs from ever being pushed while full.
  assign unused_flags = q_full ^ tag_full;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp_keep),
    .clear (redirect_valid),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_prefetch_q (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep),
    .pop   (q_pop),
    .clear (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (accept)         pc <= pc + XLEN'(4);
  end

  // A response landing in the redirect cycle retires one in-flight request itself.
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (redirect_valid)
      drop_cnt <= (imem_rsp_valid && outstanding != '0) ? outstanding - 1'b1 : outstanding;
    else if (rsp_drop)
      drop_cnt <= drop_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_IF || redirect_valid) begin
      valid_IF            <= 1'b0;
      instrCode_IF        <= NOP_INSTR;
      PCOutData_IF        <= '0;
      PC_4_AdderResult_IF <= '0;
    end else if (stall) begin
      valid_IF            <= valid_IF;
    end else if (!q_empty) begin
      valid_IF            <= 1'b1;
      instrCode_IF        <= q_dout.instr;
      PCOutData_IF        <= q_dout.pc;
      PC_4_AdderResult_IF <= q_dout.pc + XLEN'(4);
    end else begin
      valid_IF            <= 1'b0;
      instrCode_IF        <= NOP_INSTR;
      PCOutData_IF        <= '0;
      PC_4_AdderResult_IF <= '0;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: in-order variable-latency memory model, expected stream queue,
// decoupled IF/ID monitor plus directed cycle checks.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, stall, flush_IF, valid_IF;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic [31:0] instrCode_IF, PCOutData_IF, PC_4_AdderResult_IF;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk                 (clk),
    .reset               (reset),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_rsp_valid      (imem_rsp_valid),
    .imem_rsp_data       (imem_rsp_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .stall               (stall),
    .flush_IF            (flush_IF),
    .valid_IF            (valid_IF),
    .instrCode_IF        (instrCode_IF),
    .PCOutData_IF        (PCOutData_IF),
    .PC_4_AdderResult_IF (PC_4_AdderResult_IF)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mq[$];
  int    checks = 0, errors = 0, n_pop = 0, lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_stream(input logic [31:0] pc0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] p;
      p = pc0 + 32'(4 * i);
      exp_q.push_back('{p, mem_word(p), p + 32'd4});
    end
  endtask

  // In-order memory: request accepted at edge k is presented during the cycle before edge k+lat.
  logic        m_fire, m_rs;
  logic [31:0] m_addr;
  int          m_cyc = 0;
  mreq_t       m_head;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      m_fire = imem_req_valid && imem_req_ready;
      m_addr = imem_req_addr;
      m_rs   = reset;
      #1;
      m_cyc++;
      if (m_rs) mq.delete();
      else if (m_fire) mq.push_back('{m_addr, m_cyc + lat - 1});
      imem_rsp_valid = 1'b0;
      if (!m_rs && mq.size() > 0 && mq[0].due <= m_cyc) begin
        m_head = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m_head.addr);
      end
    end
  end

  // A fresh instruction is on IF/ID whenever valid_IF is set after an edge without stall.
  logic mon_st;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      mon_st = stall;
      #2;
      if (valid_IF && !mon_st) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h expected none", PCOutData_IF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("if_pc",    PCOutData_IF,        mon_e.pc);
          chk("if_instr", instrCode_IF,        mon_e.instr);
          chk("if_pc4",   PC_4_AdderResult_IF, mon_e.pc4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int          n0;
  logic [31:0] h_pc, h_instr;

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    stall = 1'b0; flush_IF = 1'b0; lat = 1;

    // Reset state and first-instruction latency
    step(); step();
    chk("rst_valid", 32'(valid_IF), 32'd0);
    chk("rst_instr", instrCode_IF, 32'h0000_0013);
    chk("rst_pc",    PCOutData_IF, 32'd0);
    chk("rst_pc4",   PC_4_AdderResult_IF, 32'd0);
    chk("rst_req",   32'(imem_req_valid), 32'd0);
    restart_stream(32'h100);
    reset = 1'b0;
    #1;
    chk("first_req_addr", imem_req_addr, 32'h100);
    step(); chk("e1_valid", 32'(valid_IF), 32'd0);
    step(); chk("e2_valid", 32'(valid_IF), 32'd0);
    step(); chk("e3_valid", 32'(valid_IF), 32'd1);
    chk("e3_pc", PCOutData_IF, 32'h100);
    chk("e3_pc4", PC_4_AdderResult_IF, 32'h104);
    step(); chk("e4_pc", PCOutData_IF, 32'h104);
    step(); chk("e5_pc", PCOutData_IF, 32'h108);
    repeat (4) step();

    // Mid-run reset, then memory not ready for 10 cycles
    reset = 1'b1; imem_req_ready = 1'b0;
    step();
    restart_stream(32'h100);
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("noready_addr",  imem_req_addr, 32'h100);
      chk("noready_valid", 32'(valid_IF), 32'd0);
      step();
    end
    imem_req_ready = 1'b1;
    n0 = n_pop;
    repeat (8) step();
    chk("noready_resume", 32'(n_pop - n0 >= 4), 32'd1);

    // Stall holds IF/ID; credits run out once outstanding+queue reaches DEPTH
    stall = 1'b1;
    h_pc = PCOutData_IF; h_instr = instrCode_IF;
    chk("stall_pre_valid", 32'(valid_IF), 32'd1);
    repeat (6) begin
      step();
      chk("stall_hold_pc",    PCOutData_IF, h_pc);
      chk("stall_hold_instr", instrCode_IF, h_instr);
      chk("stall_hold_valid", 32'(valid_IF), 32'd1);
    end
    #1;
    chk("stall_credit", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    n0 = n_pop;
    repeat (8) step();
    chk("stall_resume", 32'(n_pop - n0 >= 6), 32'd1);

    // 3-cycle memory, redirect with 3 requests in flight
    reset = 1'b1; lat = 3;
    step();
    restart_stream(32'h400);
    step();
    reset = 1'b0;
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    #1;
    chk("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("redir_rsp_same_cycle", 32'(imem_rsp_valid), 32'd1);
    step();
    chk("redir_bubble", 32'(valid_IF), 32'd0);
    redirect_valid = 1'b0;
    #1;
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr",  imem_req_addr, 32'h400);
    n0 = n_pop;
    repeat (12) step();
    chk("redir_resume", 32'(n_pop - n0 >= 2), 32'd1);

    // Redirect + flush + stall while a response is arriving
    lat = 1;
    repeat (8) step();
    chk("combo_pre_valid", 32'(valid_IF), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h800; flush_IF = 1'b1; stall = 1'b1;
    #1;
    chk("combo_rsp", 32'(imem_rsp_valid), 32'd1);
    step();
    chk("combo_valid", 32'(valid_IF), 32'd0);
    chk("combo_instr", instrCode_IF, 32'h0000_0013);
    chk("combo_pc",    PCOutData_IF, 32'd0);
    chk("combo_pc4",   PC_4_AdderResult_IF, 32'd0);
    restart_stream(32'h800);
    redirect_valid = 1'b0; flush_IF = 1'b0; stall = 1'b0;
    n0 = n_pop;
    repeat (8) step();
    chk("combo_resume", 32'(n_pop - n0 >= 3), 32'd1);

    // Address wrap at the top of the PC space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    restart_stream(32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr",  imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    n0 = n_pop;
    repeat (6) step();
    chk("wrap_resume", 32'(n_pop - n0 >= 3), 32'd1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-cycle ROM fetch with a valid/ready instruction-memory request port that tolerates variable response latency. Up to DEPTH fetches can be in flight or buffered, and branch redirects discard stale responses. It drives the IF/ID pipeline register consumed by the decode stage and obeys the hazard unit's stall/flush controls.

## Interface
Parameters:
- XLEN, 32, PC/address width (instructions are always 32 bit)
- DEPTH, 4, prefetch queue entries plus outstanding requests; power of two, ≥2
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address (current PC)
- imem_rsp_valid  in  1  in-order response, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  target address
- stall  in  1  hold IF/ID register
- flush_IF  in  1  bubble IF/ID register
- valid_IF  out  1  IF/ID holds a real instruction
- instrCode_IF  out  32  instruction
- PCOutData_IF  out  XLEN  instruction PC
- PC_4_AdderResult_IF  out  XLEN  PC+4

## Operation
- Fetch PC register: reset → RESET_PC. Increments by 4 on every accepted request (imem_req_valid && imem_req_ready). Loads redirect_pc on redirect_valid; redirect takes priority over increment.
- Credit rule: imem_req_valid = !reset && !redirect_valid && (outstanding + queue_count < DEPTH).
- Each accepted request pushes its PC into a pc-tag FIFO. Each kept response pops the tag and pushes {pc, instr} into the prefetch queue.
- Redirect: clears the prefetch queue and pc-tag FIFO. Loads drop_cnt with outstanding minus any response arriving that same cycle. While drop_cnt > 0, responses are discarded and drop_cnt decrements. Requests resume the cycle after the redirect, even while drop_cnt > 0. Those new requests are ordered after the dropped ones.
- IF/ID register priority, per edge:
  - reset: valid_IF=0, instr=NOP_INSTR, PC fields 0.
  - else flush_IF or redirect_valid: same bubble values.
  - else stall: hold all fields.
  - else queue non-empty: pop the head, valid_IF=1, PC_4 = pc+4 mod 2^XLEN.
  - else: bubble.
- Queue push and pop in the same cycle are legal at any occupancy, including full.
- outstanding counter is $clog2(DEPTH)+1 bits and never exceeds DEPTH.

## Timing
- All outputs are registered except imem_req_valid/imem_req_addr. These are combinational from the PC, the counters and redirect_valid.
- Reset values: PC=RESET_PC, queue empty, outstanding=0, drop_cnt=0, valid_IF=0, instrCode_IF=NOP_INSTR, PCOutData_IF=0, PC_4_AdderResult_IF=0.
- Best-case latency with 1-cycle memory: request accepted at edge E1, response captured into the queue at E2, visible on IF/ID after E3. Steady state is one instruction per cycle once the queue is primed. There is no empty-queue bypass.
- Redirect sampled at edge E0: first request to redirect_pc issued in the cycle after E0. valid_IF=0 from E0 until the first kept response is popped.
- Redirect and stall together: redirect wins and IF/ID is bubbled.
- Response arriving in the redirect cycle is dropped.
- Reset mid-operation: all counters cleared. Responses to pre-reset requests are the memory's responsibility; the memory is reset on the same signal.

## Structure
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013 (addi x0,x0,0)
  - fetch_entry_t struct {pc, instr}, parametrised by XLEN
- Sub-module fetch_fifo: synchronous FIFO parametrised by entry type width and DEPTH. Ports: push, pop, clear, full, empty, count. Instantiated twice, for the pc-tag FIFO and the prefetch queue.

## Test plan
- Reset, RESET_PC=0x100, ready always high, 1-cycle memory → valid_IF first at the 3rd edge after reset release with PC 0x100. Then 0x104, 0x108 on consecutive cycles; PC_4 = PC+4.
- imem_req_ready held low for 10 cycles → imem_req_addr stable at 0x100, valid_IF=0 throughout, no duplicate PCs afterwards.
- stall held 6 cycles with DEPTH=4 → IF/ID holds its value. Requests stop once outstanding+count=4. After release, PCs continue with no gap or repeat.
- 3-cycle memory latency, redirect to 0x400 while 3 requests outstanding → 3 responses dropped. Next valid_IF has PC 0x400, instr = memory word at 0x400.
- Redirect, flush_IF and stall in the same cycle as a response → IF/ID bubbled (valid_IF=0, instr 0x00000013). Response discarded.
- XLEN=32, redirect to 0xFFFF_FFFC → PC_4_AdderResult_IF=0x0, next fetch address 0x0000_0000.
